// File: rtl/apb_master_ctrl.sv
// APB initiator: turns single-word client commands into SETUP/ACCESS transfers
// and returns one response per command, with an optional wait-state timeout.
//
// state  | meaning
// IDLE   | bus parked, accepting a command
// SETUP  | pSelect high, address/control presented
// ACCESS | pEnable high, waiting for pReady or timeout
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              pSelect,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddress,
  output logic [DATA_W-1:0] pWData,
  input  logic [DATA_W-1:0] pRData,
  input  logic              pReady,
  input  logic              pSlvErr
);

  // A zero TIMEOUT still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] waitCnt;
  logic             accept, done, abort;

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    cmd_ready = 1'b0;
    pSelect   = 1'b0;
    pEnable   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        pSelect   = 1'b1;
        stateNext = ACCESS;
      end
      ACCESS: begin
        pSelect = 1'b1;
        pEnable = 1'b1;
        // Completion takes priority over a timeout firing in the same cycle.
        if (pReady) begin
          done      = 1'b1;
          stateNext = IDLE;
        end else if (TO_EN && (waitCnt == TO_LAST)) begin
          abort     = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (!pReset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      pWrite      <= 1'b0;
      pAddress    <= '0;
      pWData      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= stateNext;
      rsp_valid <= done | abort;
      if (accept) begin
        pWrite   <= cmd_write;
        pAddress <= cmd_addr;
        pWData   <= cmd_wdata;
      end
      if (state == SETUP) begin
        waitCnt <= '0;
      end else if (state == ACCESS && !done && !abort && waitCnt != '1) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (done) begin
        rsp_rdata   <= pWrite ? '0 : pRData;
        rsp_err     <= pSlvErr;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
